// File: rtl/hs32_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : hs32_wb_master
// Brief    : Wishbone B4 classic master bridge for the hs32 CPU memory bus.
//            Accepts single-cycle CPU requests, runs one registered Wishbone
//            cycle, bounds it with a timeout, and reports err/timeout as a
//            fault pulse alongside the CPU ack.
// Revision : 1.0 - initial release
// ============================================================================
module hs32_wb_master #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] dtw,
    output logic [31:0] dtr,
    output logic        ack,
    output logic        fault,
    output logic        drop,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    state_t      r_state, w_state_next;
    logic [7:0]  r_cnt, w_cnt_next;
    logic        r_cyc, w_cyc_next;
    logic        r_stb, w_stb_next;
    logic        r_we, w_we_next;
    logic [3:0]  r_sel, w_sel_next;
    logic [31:0] r_adr, w_adr_next;
    logic [31:0] r_dat, w_dat_next;
    logic [31:0] r_dtr, w_dtr_next;
    logic        r_ack, w_ack_next;
    logic        r_fault, w_fault_next;
    logic        r_drop, w_drop_next;

    // Register every state bit and every output; reset clears all of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 4'h0;
            r_adr   <= 32'd0;
            r_dat   <= 32'd0;
            r_dtr   <= 32'd0;
            r_ack   <= 1'b0;
            r_fault <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_cyc   <= w_cyc_next;
            r_stb   <= w_stb_next;
            r_we    <= w_we_next;
            r_sel   <= w_sel_next;
            r_adr   <= w_adr_next;
            r_dat   <= w_dat_next;
            r_dtr   <= w_dtr_next;
            r_ack   <= w_ack_next;
            r_fault <= w_fault_next;
            r_drop  <= w_drop_next;
        end
    end

    // Next-state and next-output decode; bus outputs hold unless changed.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cyc_next   = r_cyc;
        w_stb_next   = r_stb;
        w_we_next    = r_we;
        w_sel_next   = r_sel;
        w_adr_next   = r_adr;
        w_dat_next   = r_dat;
        w_dtr_next   = r_dtr;
        w_ack_next   = 1'b0;
        w_fault_next = 1'b0;
        // A request that arrives while busy is lost; remember that it happened.
        w_drop_next  = r_drop | (stb && (r_state != S_IDLE));

        case (r_state)
            S_IDLE: begin
                if (stb) begin
                    w_cyc_next   = 1'b1;
                    w_stb_next   = 1'b1;
                    w_we_next    = rw;
                    w_sel_next   = 4'hF;
                    w_adr_next   = addr & 32'hFFFF_FFFC;
                    w_dat_next   = dtw;
                    w_cnt_next   = 8'd0;
                    w_state_next = S_BUS;
                end
            end
            S_BUS: begin
                // Error outranks a simultaneous ack; an expired count behaves as an error.
                if (wbm_err_i || (!wbm_ack_i && (r_cnt == c_TIMEOUT))) begin
                    w_cyc_next   = 1'b0;
                    w_stb_next   = 1'b0;
                    w_we_next    = 1'b0;
                    w_sel_next   = 4'h0;
                    w_ack_next   = 1'b1;
                    w_fault_next = 1'b1;
                    w_dtr_next   = r_we ? 32'd0 : ERR_DATA;
                    w_state_next = S_RESP;
                end else if (wbm_ack_i) begin
                    w_cyc_next   = 1'b0;
                    w_stb_next   = 1'b0;
                    w_we_next    = 1'b0;
                    w_sel_next   = 4'h0;
                    w_ack_next   = 1'b1;
                    w_dtr_next   = r_we ? 32'd0 : wbm_dat_i;
                    w_state_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign dtr       = r_dtr;
    assign ack       = r_ack;
    assign fault     = r_fault;
    assign drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_hs32_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs32_wb_master
// Brief    : Directed bench for hs32_wb_master. Expected CPU responses are
//            queued when a request is issued and compared when ack appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs32_wb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, rw;
    logic [31:0] addr, dtw;
    logic [31:0] dtr;
    logic        ack, fault, drop;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;

    int checks = 0;
    int errors = 0;

    // Expected {fault, dtr} for each CPU ack still outstanding.
    logic [32:0] sb[$];

    hs32_wb_master #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst), .stb(stb), .rw(rw), .addr(addr), .dtw(dtw),
        .dtr(dtr), .ack(ack), .fault(fault), .drop(drop),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled and inputs driven at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every CPU ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            logic [32:0] e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL unexpected_ack: observed ack=1 fault=%b dtr=%h expected no ack", fault, dtr);
            end else begin
                e = sb.pop_front();
                assert ({fault, dtr} === e) else begin
                    errors++;
                    $error("FAIL sb_resp: observed fault=%b dtr=%h expected fault=%b dtr=%h",
                           fault, dtr, e[32], e[31:0]);
                end
            end
        end
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stb = 1'b0; rw = 1'b0; addr = '0; dtw = '0;
        wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        tick(); tick(); tick();
        chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
        chk("rst_sel", {28'd0, wbm_sel_o}, 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dtr", dtr, 32'd0);
        chk("rst_ack_fault_drop", {29'd0, ack, fault, drop}, 32'd0);
        rst = 1'b0;
        tick();

        // Read, zero-wait slave
        stb = 1'b1; rw = 1'b0; addr = 32'h0000_1006;
        sb.push_back({1'b0, 32'h1234_5678});
        tick();
        stb = 1'b0;
        chk("rd_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd3);
        chk("rd_we", {31'd0, wbm_we_o}, 32'd0);
        chk("rd_adr", wbm_adr_o, 32'h0000_1004);
        chk("rd_sel", {28'd0, wbm_sel_o}, 32'hF);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678;
        tick();
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        chk("rd_ack", {31'd0, ack}, 32'd1);
        chk("rd_cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);
        tick();
        chk("rd_ack_gone", {31'd0, ack}, 32'd0);
        chk("rd_dtr_hold", dtr, 32'h1234_5678);

        // Write, 3-wait slave, with an extra stb during BUS
        stb = 1'b1; rw = 1'b1; addr = 32'h0000_2000; dtw = 32'hA5A5_0001;
        sb.push_back({1'b0, 32'h0});
        for (int i = 1; i <= 4; i++) begin
            tick();
            stb = 1'b0; rw = 1'b0; dtw = 32'h0;
            chk("wr_cyc", {31'd0, wbm_cyc_o}, 32'd1);
            chk("wr_we", {31'd0, wbm_we_o}, 32'd1);
            chk("wr_dat", wbm_dat_o, 32'hA5A5_0001);
            chk("wr_adr", wbm_adr_o, 32'h0000_2000);
            if (i == 2) begin
                stb = 1'b1; addr = 32'h0000_9000; dtw = 32'h1111_2222;
            end
            if (i == 3) chk("wr_drop", {31'd0, drop}, 32'd1);
            if (i == 4) wbm_ack_i = 1'b1;
        end
        tick();
        wbm_ack_i = 1'b0;
        chk("wr_ack", {31'd0, ack}, 32'd1);
        // stb in RESP must be ignored
        stb = 1'b1; rw = 1'b0; addr = 32'h0000_7000;
        tick();
        stb = 1'b0;
        chk("wr_single_ack", {31'd0, ack}, 32'd0);
        chk("resp_stb_ignored", {31'd0, wbm_cyc_o}, 32'd0);

        // Error together with ack on a read
        stb = 1'b1; rw = 1'b0; addr = 32'h0000_3008;
        sb.push_back({1'b1, 32'hDEAD_BEEF});
        tick();
        stb = 1'b0;
        tick();
        wbm_err_i = 1'b1; wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000_0055;
        tick();
        wbm_err_i = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        chk("err_ack_fault", {30'd0, ack, fault}, 32'd3);
        chk("err_bus_idle", {26'd0, wbm_cyc_o, wbm_stb_o, wbm_sel_o}, 32'd0);
        tick();
        chk("err_fault_gone", {31'd0, fault}, 32'd0);

        // Timeout with silent slave
        stb = 1'b1; rw = 1'b0; addr = 32'h0000_5000;
        sb.push_back({1'b1, 32'hDEAD_BEEF});
        for (int i = 1; i <= 5; i++) begin
            tick();
            stb = 1'b0;
            chk("to_cyc_held", {30'd0, wbm_cyc_o, ack}, 32'd2);
        end
        tick();
        chk("to_end", {29'd0, wbm_cyc_o, ack, fault}, 32'd3);
        tick();
        // Normal read after timeout
        stb = 1'b1; rw = 1'b0; addr = 32'h0000_4003;
        sb.push_back({1'b0, 32'hCAFE_F00D});
        tick();
        stb = 1'b0;
        chk("rd2_adr", wbm_adr_o, 32'h0000_4000);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
        tick();
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        chk("rd2_ack", {30'd0, ack, fault}, 32'd2);
        tick();

        // Reset while in BUS: no ack, drop cleared
        stb = 1'b1; rw = 1'b0; addr = 32'h0000_6000;
        tick();
        stb = 1'b0;
        chk("rb_cyc", {31'd0, wbm_cyc_o}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_abort", {29'd0, wbm_cyc_o, wbm_stb_o, ack}, 32'd0);
        chk("rb_drop", {31'd0, drop}, 32'd0);
        // Stray slave ack in IDLE must not produce a CPU ack
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("idle_ack_ignored", {31'd0, ack}, 32'd0);
        tick(); tick();

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hs32_wb_master.md
Name: hs32_wb_master

Overview:
- Wishbone B4 classic master bridge driven by the hs32 CPU memory bus (stb/ack/rw/addr/dtw/dtr).
- Lets the core issue transactions out to an external Wishbone slave, i.e. the initiator side of the responder path the user project exposes to Caravel.
- Sits between the CPU/MMIO request side and an external Wishbone port.
- Registers all Wishbone outputs, bounds every cycle with a timeout, and reports bus errors back as a fault.

Parameters:
- TIMEOUT, 255: max cycles CYC may stay high without ack/err before forced termination; 8-bit counter width (legal 1..255).
- ERR_DATA, 32'hDEAD_BEEF: value returned on dtr for an errored or timed-out read.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- stb  input  1  CPU request strobe, single-cycle pulse; accepted only in IDLE
- rw  input  1  1 = write, 0 = read; sampled with stb
- addr  input  32  byte address; sampled with stb
- dtw  input  32  write data; sampled with stb
- dtr  output  32  read data; valid in the ack cycle
- ack  output  1  single-cycle completion pulse to CPU
- fault  output  1  single-cycle pulse coincident with ack on err_i or timeout
- drop  output  1  sticky: stb seen while not IDLE; cleared only by rst
- wbm_cyc_o  output  1  Wishbone CYC
- wbm_stb_o  output  1  Wishbone STB
- wbm_we_o  output  1  Wishbone WE
- wbm_sel_o  output  4  byte selects, always 4'hF during a cycle, 4'h0 otherwise
- wbm_adr_o  output  32  {addr[31:2], 2'b00}
- wbm_dat_o  output  32  write data
- wbm_dat_i  input  32  read data from slave
- wbm_ack_i  input  1  slave ack
- wbm_err_i  input  1  slave error

Behaviour:
- Reset values: all outputs 0; state = IDLE; timeout counter = 0; drop = 0.
- Reset mid-operation: CYC/STB drop at the next edge; no ack is generated for the aborted request.
- State IDLE:
  - stb=1 → latch rw/addr/dtw into the Wishbone output registers.
  - Next cycle: cyc=stb=1, we=rw, sel=4'hF; go to BUS; counter = 0.
- State BUS: outputs held stable; counter increments each cycle.
  - err_i=1 (wins over a simultaneous ack_i) → next cycle: cyc=stb=we=sel=0, ack=1, fault=1, dtr=ERR_DATA for reads (0 for writes); go to RESP.
  - ack_i=1, err_i=0 → next cycle: cyc=stb=0, ack=1, fault=0, dtr=wbm_dat_i for reads (0 for writes); go to RESP.
  - Counter reaches TIMEOUT with no ack/err → same as the err_i path (fault=1).
- State RESP: ack/fault high for exactly this one cycle; return to IDLE.
  - A new stb in this cycle is not accepted.
- Latency:
  - stb at cycle 0 → cyc=1 at cycle 1.
  - Slave ack at cycle k → CPU ack at cycle k+1.
  - Minimum round trip: stb@0, ack_i@1, ack@2.
- Protocol and data rules:
  - stb in BUS or RESP is ignored and sets drop=1.
  - dtr holds its value between acks.
  - ack_i/err_i arriving in IDLE or RESP are ignored.
  - addr[1:0] is discarded.
  - Only 32-bit transfers; no bursts; CTI/BTE not driven.

Test Plan:
- Read, zero-wait slave: stb, rw=0, addr=0x0000_1006 → cycle 1: cyc=stb=1, we=0, adr=0x0000_1004, sel=F; slave acks @1 with 0x1234_5678 → ack=1, dtr=0x1234_5678, fault=0 @2; cyc=0 @2.
- Write, 3-wait slave: stb, rw=1, dtw=0xA5A5_0001 → dat_o=0xA5A5_0001, we=1 held stable for 4 cycles; ack_i @4 → ack @5; exactly one ack pulse.
- Error: slave asserts err_i and ack_i together @2 on a read → ack=1, fault=1, dtr=0xDEAD_BEEF @3.
- Timeout with TIMEOUT=4: slave silent → cyc drops and ack+fault pulse exactly at cycle 1+4+1; subsequent read completes normally.
- Drop/reset: stb while in BUS → drop=1 and the transaction is unaffected; rst asserted in BUS → cyc=stb=0 next cycle, no ack, drop=0.
